// File: rtl/bsg_rocket_trace_replay_ctrl.sv
// Trace replay controller: walks a trace ROM and drives/checks a rocket node fsb port.
// Define BSG_ROCKET_REPLAY_MISMATCH_HALT_EN to stop replay on the first RECV mismatch.
module bsg_rocket_trace_replay_ctrl #(
    parameter int rom_addr_width_p = 8,
    parameter int rom_els_p        = 256,
    parameter int counter_width_p  = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [83:0]                 rom_data_i,
    output logic                        v_o,
    output logic [79:0]                 data_o,
    input  logic                        ready_i,
    input  logic                        v_i,
    input  logic [79:0]                 data_i,
    output logic                        yumi_o,
    output logic                        done_o,
    output logic                        finish_o,
    output logic                        error_o,
    output logic [15:0]                 err_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DONE   = 2'd1,
        S_FINISH = 2'd2,
        S_HALT   = 2'd3
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_SEND = 4'b0001;
    localparam logic [3:0] OP_RECV = 4'b0010;
    localparam logic [3:0] OP_DONE = 4'b0011;
    localparam logic [3:0] OP_END  = 4'b0100;
    localparam logic [3:0] OP_WCNT = 4'b0101;
    localparam logic [3:0] OP_ICNT = 4'b0110;

    localparam logic [rom_addr_width_p-1:0] last_addr_lp = rom_addr_width_p'(rom_els_p - 1);

    state_e                        state_q, state_d;
    logic [rom_addr_width_p-1:0]   addr_q, addr_d;
    logic [counter_width_p-1:0]    cnt_q, cnt_d;
    logic                          error_q, error_d;
    logic [15:0]                   err_cnt_q, err_cnt_d;
    logic                          advance;
    logic [3:0]                    op;

    assign op = rom_data_i[83:80];

    // NOTE: every combinational output/next-state gets a default first so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        v_o       = 1'b0;
        yumi_o    = 1'b0;
        advance   = 1'b0;

        // Outputs are also held quiet while reset is asserted, not just after it.
        if (state_q == S_RUN && en_i && !reset_i) begin
            case (op)
                OP_NOP:  advance = 1'b1;
                OP_SEND: begin
                    v_o     = 1'b1;
                    advance = ready_i;
                end
                OP_RECV: begin
                    yumi_o = v_i;
                    if (v_i) begin
                        if (data_i != rom_data_i[79:0]) begin
                            error_d = 1'b1;
                            if (err_cnt_q != 16'hFFFF)
                                err_cnt_d = err_cnt_q + 16'd1;
`ifdef BSG_ROCKET_REPLAY_MISMATCH_HALT_EN
                            state_d = S_HALT;
`else
                            advance = 1'b1;
`endif
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                OP_DONE: state_d = S_DONE;
                OP_END:  state_d = S_FINISH;
                OP_WCNT: begin
                    if (cnt_q == '0)
                        advance = 1'b1;
                    else
                        cnt_d = cnt_q - counter_width_p'(1);
                end
                OP_ICNT: begin
                    cnt_d   = rom_data_i[counter_width_p-1:0];
                    advance = 1'b1;
                end
                default: begin
                    error_d = 1'b1;
                    state_d = S_HALT;
                end
            endcase
        end

        // Running off the end of the ROM finishes the trace rather than wrapping.
        if (advance) begin
            if (addr_q == last_addr_lp)
                state_d = S_DONE;
            else
                addr_d = addr_q + rom_addr_width_p'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_RUN;
            addr_q    <= '0;
            cnt_q     <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rom_addr_o = addr_q;
    assign data_o     = rom_data_i[79:0];
    assign done_o     = (state_q == S_DONE);
    assign finish_o   = (state_q == S_FINISH);
    assign error_o    = error_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_bsg_rocket_trace_replay_ctrl.sv
// Directed bench for bsg_rocket_trace_replay_ctrl using a 4-entry trace ROM.
// Expectations follow BSG_ROCKET_REPLAY_MISMATCH_HALT_EN when the bench is built with it.
module tb_bsg_rocket_trace_replay_ctrl;

    logic        clk;
    logic        reset_i;
    logic        en_i;
    logic [7:0]  rom_addr_o;
    logic [83:0] rom_data_i;
    logic        v_o;
    logic [79:0] data_o;
    logic        ready_i;
    logic        v_i;
    logic [79:0] data_i;
    logic        yumi_o;
    logic        done_o;
    logic        finish_o;
    logic        error_o;
    logic [15:0] err_cnt_o;

    logic [83:0] rom [4];
    int n_tests = 0;
    int n_fail  = 0;

    assign rom_data_i = rom[rom_addr_o[1:0]];

    bsg_rocket_trace_replay_ctrl #(
        .rom_addr_width_p(8),
        .rom_els_p       (4),
        .counter_width_p (16)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .en_i      (en_i),
        .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .yumi_o    (yumi_o),
        .done_o    (done_o),
        .finish_o  (finish_o),
        .error_o   (error_o),
        .err_cnt_o (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [83:0] ent(input logic [3:0] op, input logic [79:0] pkt);
        return {op, pkt};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset away from the clock edge, checks the reset state, releases.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_i = 1'b1;
        #1;
        check("rst_addr",    96'(rom_addr_o), 96'd0);
        check("rst_v_o",     96'(v_o),        96'd0);
        check("rst_yumi",    96'(yumi_o),     96'd0);
        check("rst_done",    96'(done_o),     96'd0);
        check("rst_finish",  96'(finish_o),   96'd0);
        check("rst_error",   96'(error_o),    96'd0);
        check("rst_err_cnt", 96'(err_cnt_o),  96'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        #1;
    endtask

    initial begin
        reset_i = 1'b0;
        en_i    = 1'b1;
        ready_i = 1'b1;
        v_i     = 1'b0;
        data_i  = '0;
        for (int i = 0; i < 4; i++) rom[i] = ent(4'b0000, '0);

        // SEND, SEND, DONE with ready high; a response during SEND is not consumed.
        rom[0] = ent(4'b0001, 80'hA0A0);
        rom[1] = ent(4'b0001, 80'hB1B1);
        rom[2] = ent(4'b0011, '0);
        rom[3] = ent(4'b0000, '0);
        do_reset();
        v_i = 1'b1;
        #1;
        check("ss_c0_v",    96'(v_o),    96'd1);
        check("ss_c0_data", 96'(data_o), 96'hA0A0);
        check("ss_c0_yumi", 96'(yumi_o), 96'd0);
        cyc();
        check("ss_c1_v",    96'(v_o),    96'd1);
        check("ss_c1_data", 96'(data_o), 96'hB1B1);
        check("ss_c1_addr", 96'(rom_addr_o), 96'd1);
        v_i = 1'b0;
        cyc();
        check("ss_c2_v",    96'(v_o),    96'd0);
        check("ss_c2_done", 96'(done_o), 96'd0);
        cyc();
        check("ss_c3_done", 96'(done_o), 96'd1);
        check("ss_c3_addr", 96'(rom_addr_o), 96'd2);

        // SEND stalled by ready low for 5 cycles, then an en_i drop, then retire.
        rom[0] = ent(4'b0001, 80'h1234_5678_9ABC);
        rom[1] = ent(4'b0011, '0);
        ready_i = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("stall_v",    96'(v_o),        96'd1);
            check("stall_addr", 96'(rom_addr_o), 96'd0);
            check("stall_data", 96'(data_o),     96'h1234_5678_9ABC);
            cyc();
        end
        en_i = 1'b0;
        #1;
        check("en_off_v", 96'(v_o), 96'd0);
        cyc();
        check("en_off_addr", 96'(rom_addr_o), 96'd0);
        en_i    = 1'b1;
        ready_i = 1'b1;
        #1;
        check("retire_v", 96'(v_o), 96'd1);
        cyc();
        check("retire_addr", 96'(rom_addr_o), 96'd1);
        check("retire_v_off", 96'(v_o), 96'd0);

        // ICNT 3, WCNT, SEND: SEND valid exactly 5 cycles after ICNT.
        rom[0] = ent(4'b0110, 80'd3);
        rom[1] = ent(4'b0101, '0);
        rom[2] = ent(4'b0001, 80'hC0DE);
        rom[3] = ent(4'b0011, '0);
        do_reset();
        check("icnt_v", 96'(v_o), 96'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("wcnt_v",    96'(v_o),        96'd0);
            check("wcnt_addr", 96'(rom_addr_o), 96'd1);
        end
        cyc();
        check("wsend_v",    96'(v_o),        96'd1);
        check("wsend_addr", 96'(rom_addr_o), 96'd2);

        // RECV match, then RECV expecting 1 but receiving 2.
        rom[0] = ent(4'b0010, 80'h5);
        rom[1] = ent(4'b0010, 80'h1);
        rom[2] = ent(4'b0011, '0);
        rom[3] = ent(4'b0000, '0);
        do_reset();
        #1;
        check("recv_idle_yumi", 96'(yumi_o), 96'd0);
        cyc();
        check("recv_idle_addr", 96'(rom_addr_o), 96'd0);
        v_i    = 1'b1;
        data_i = 80'h5;
        #1;
        check("recv_ok_yumi", 96'(yumi_o), 96'd1);
        cyc();
        check("recv_ok_addr",  96'(rom_addr_o), 96'd1);
        check("recv_ok_error", 96'(error_o),    96'd0);
        data_i = 80'h2;
        #1;
        check("recv_bad_yumi", 96'(yumi_o), 96'd1);
        cyc();
        v_i = 1'b0;
        check("recv_bad_error",   96'(error_o),   96'd1);
        check("recv_bad_err_cnt", 96'(err_cnt_o), 96'd1);
        cyc();
`ifdef BSG_ROCKET_REPLAY_MISMATCH_HALT_EN
        check("recv_halt_addr", 96'(rom_addr_o), 96'd1);
        check("recv_halt_done", 96'(done_o),     96'd0);
`else
        check("recv_cont_addr", 96'(rom_addr_o), 96'd2);
        check("recv_cont_done", 96'(done_o),     96'd1);
`endif
        check("recv_err_sticky", 96'(error_o), 96'd1);

        // Illegal op at address 2 halts with the address frozen.
        rom[0] = ent(4'b0000, '0);
        rom[1] = ent(4'b0000, '0);
        rom[2] = ent(4'b1111, '0);
        rom[3] = ent(4'b0000, '0);
        do_reset();
        cyc();
        cyc();
        check("ill_pre_error", 96'(error_o),    96'd0);
        check("ill_pre_addr",  96'(rom_addr_o), 96'd2);
        cyc();
        cyc();
        check("ill_error", 96'(error_o),    96'd1);
        check("ill_addr",  96'(rom_addr_o), 96'd2);
        check("ill_done",  96'(done_o),     96'd0);

        // Four NOPs exhaust the ROM; then a mid-run reset returns to the start.
        rom[2] = ent(4'b0000, '0);
        do_reset();
        cyc();
        cyc();
        cyc();
        check("nop_addr3", 96'(rom_addr_o), 96'd3);
        check("nop_done3", 96'(done_o),     96'd0);
        cyc();
        check("nop_done4", 96'(done_o),     96'd1);
        check("nop_addr4", 96'(rom_addr_o), 96'd3);
        do_reset();
        cyc();
        check("mid_pre_addr", 96'(rom_addr_o), 96'd1);
        do_reset();
        check("mid_post_addr", 96'(rom_addr_o), 96'd0);

        // END op.
        rom[0] = ent(4'b0100, '0);
        do_reset();
        check("end_pre_finish", 96'(finish_o), 96'd0);
        cyc();
        check("end_finish", 96'(finish_o), 96'd1);
        check("end_done",   96'(done_o),   96'd0);
        cyc();
        check("end_addr",   96'(rom_addr_o), 96'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
